// File: rtl/thresholding_axilite_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : thresholding_axilite_loader
// Purpose  : AXI-Lite master sequencer that streams a full threshold table
//            into a thresholding_axi core (s_axilite slave). Each 32-bit
//            AXI-Stream word becomes one AXI-Lite write; only one AXI-Lite
//            transaction is ever outstanding.
// Ports    : ap_clk / ap_rst_n       clock, asynchronous active-low reset
//            start / busy / done / err   control and status
//            s_axis_*                threshold word stream (channel-major,
//                                    threshold index innermost)
//            m_axilite_AW* / W* / B* write channels to the core
//            m_axilite_AR* / R*      read-back channels (verify build only)
// Options  : `define THRESH_LOADER_VERIFY_EN adds a read-back of every word
//            after its write response; a data or RRESP mismatch sets err.
//            Without it the read channels are tied off.
// Revision : 1.0  initial release
// ============================================================================
module thresholding_axilite_loader #(
  parameter int N  = 2,   // output precision; 2**N-1 thresholds per channel
  parameter int K  = 8,   // significant threshold bits per word
  parameter int C  = 4,   // channels
  parameter int PE = 2,   // processing parallelism (C = CF*PE)
  localparam int ADDR_BITS = $clog2(C / PE) + $clog2(PE) + N + 2
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [31:0]          s_axis_tdata,
  output logic                 m_axilite_AWVALID,
  input  logic                 m_axilite_AWREADY,
  output logic [ADDR_BITS-1:0] m_axilite_AWADDR,
  output logic                 m_axilite_WVALID,
  input  logic                 m_axilite_WREADY,
  output logic [31:0]          m_axilite_WDATA,
  output logic [3:0]           m_axilite_WSTRB,
  input  logic                 m_axilite_BVALID,
  output logic                 m_axilite_BREADY,
  input  logic [1:0]           m_axilite_BRESP,
  output logic                 m_axilite_ARVALID,
  input  logic                 m_axilite_ARREADY,
  output logic [ADDR_BITS-1:0] m_axilite_ARADDR,
  input  logic                 m_axilite_RVALID,
  output logic                 m_axilite_RREADY,
  input  logic [31:0]          m_axilite_RDATA,
  input  logic [1:0]           m_axilite_RRESP
);

  localparam int CF  = C / PE;
  localparam int PB  = $clog2(PE);
  localparam int CFB = $clog2(CF);
  // Counter widths are kept at least 1 bit so degenerate fields stay legal.
  localparam int PEW = (PB  > 0) ? PB  : 1;
  localparam int CFW = (CFB > 0) ? CFB : 1;

  localparam logic [N-1:0]   C_T_LAST  = N'((2 ** N) - 2);
  localparam logic [PEW-1:0] C_PE_LAST = PEW'(PE - 1);
  localparam logic [CFW-1:0] C_CF_LAST = CFW'(CF - 1);

`ifdef THRESH_LOADER_VERIFY_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_RESP  = 3'd3,
    S_VADDR = 3'd4,
    S_VDATA = 3'd5,
    S_DONE  = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_RESP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;
`endif

  state_t                 state_q;
  logic [N-1:0]           t_q;
  logic [PEW-1:0]         pe_q;
  logic [CFW-1:0]         cf_q;
  logic [K-1:0]           word_q;
  logic [ADDR_BITS-1:0]   awaddr_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   err_q;
  logic                   tready_q;
  logic                   awvalid_q;
  logic                   wvalid_q;
  logic                   bready_q;

  logic [N-1:0]           t_d;
  logic [PEW-1:0]         pe_d;
  logic [CFW-1:0]         cf_d;
  logic                   w_last;
  logic [ADDR_BITS-1:0]   w_addr;
  logic [ADDR_BITS-1:0]   w_pe_fld;
  logic [ADDR_BITS-1:0]   w_cf_fld;
  logic                   w_unused;

  // Counter advance: t innermost, then pe, then cf.
  always_comb begin
    t_d  = t_q;
    pe_d = pe_q;
    cf_d = cf_q;
    if (t_q == C_T_LAST) begin
      t_d = '0;
      if (pe_q == C_PE_LAST) begin
        pe_d = '0;
        cf_d = cf_q + CFW'(1);
      end else begin
        pe_d = pe_q + PEW'(1);
      end
    end else begin
      t_d = t_q + N'(1);
    end
  end

  assign w_last = (t_q == C_T_LAST) && (pe_q == C_PE_LAST) && (cf_q == C_CF_LAST);

  // Byte address {cf, pe, t, 2'b00}; a field vanishes when its range is 1.
  generate
    if (PB > 0) begin : g_pe_fld
      assign w_pe_fld = ADDR_BITS'(pe_q) << (N + 2);
    end else begin : g_no_pe_fld
      assign w_pe_fld = '0;
    end
    if (CFB > 0) begin : g_cf_fld
      assign w_cf_fld = ADDR_BITS'(cf_q) << (PB + N + 2);
    end else begin : g_no_cf_fld
      assign w_cf_fld = '0;
    end
  endgenerate

  assign w_addr = w_cf_fld | w_pe_fld | ADDR_BITS'({t_q, 2'b00});

`ifdef THRESH_LOADER_VERIFY_EN
  logic arvalid_q;
  logic rready_q;
  assign m_axilite_ARVALID = arvalid_q;
  assign m_axilite_RREADY  = rready_q;
  assign m_axilite_ARADDR  = awaddr_q;
  assign w_unused = ^{s_axis_tdata, m_axilite_RDATA};
`else
  assign m_axilite_ARVALID = 1'b0;
  assign m_axilite_RREADY  = 1'b0;
  assign m_axilite_ARADDR  = '0;
  assign w_unused = ^{s_axis_tdata, m_axilite_ARREADY, m_axilite_RVALID,
                      m_axilite_RDATA, m_axilite_RRESP};
`endif

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= S_IDLE;
      t_q       <= '0;
      pe_q      <= '0;
      cf_q      <= '0;
      word_q    <= '0;
      awaddr_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      tready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
`ifdef THRESH_LOADER_VERIFY_EN
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            t_q      <= '0;
            pe_q     <= '0;
            cf_q     <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b1;
            tready_q <= 1'b1;
            state_q  <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (s_axis_tvalid && tready_q) begin
            word_q    <= s_axis_tdata[K-1:0];
            awaddr_q  <= w_addr;
            tready_q  <= 1'b0;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // AW and W complete independently; leave once both have been taken.
          if (m_axilite_AWREADY) awvalid_q <= 1'b0;
          if (m_axilite_WREADY)  wvalid_q  <= 1'b0;
          if ((!awvalid_q || m_axilite_AWREADY) && (!wvalid_q || m_axilite_WREADY)) begin
            bready_q <= 1'b1;
            state_q  <= S_RESP;
          end
        end
        S_RESP: begin
          if (m_axilite_BVALID && bready_q) begin
            bready_q <= 1'b0;
            if (m_axilite_BRESP != 2'b00) err_q <= 1'b1;
`ifdef THRESH_LOADER_VERIFY_EN
            arvalid_q <= 1'b1;
            state_q   <= S_VADDR;
`else
            if (w_last) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              t_q      <= t_d;
              pe_q     <= pe_d;
              cf_q     <= cf_d;
              tready_q <= 1'b1;
              state_q  <= S_FETCH;
            end
`endif
          end
        end
`ifdef THRESH_LOADER_VERIFY_EN
        S_VADDR: begin
          if (m_axilite_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_VDATA;
          end
        end
        S_VDATA: begin
          if (m_axilite_RVALID && rready_q) begin
            rready_q <= 1'b0;
            if ((m_axilite_RRESP != 2'b00) || (m_axilite_RDATA[K-1:0] != word_q))
              err_q <= 1'b1;
            if (w_last) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              t_q      <= t_d;
              pe_q     <= pe_d;
              cf_q     <= cf_d;
              tready_q <= 1'b1;
              state_q  <= S_FETCH;
            end
          end
        end
`endif
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign err               = err_q;
  assign s_axis_tready     = tready_q;
  assign m_axilite_AWVALID = awvalid_q;
  assign m_axilite_AWADDR  = awaddr_q;
  assign m_axilite_WVALID  = wvalid_q;
  assign m_axilite_WDATA   = {{(32 - K){1'b0}}, word_q};
  assign m_axilite_WSTRB   = 4'hF;
  assign m_axilite_BREADY  = bready_q;

endmodule
`default_nettype wire
